// File: rtl/callstk_pkg.sv
// Shared types and constants for the call-stack controller and its attached LIFO stack.
package callstk_pkg;

  localparam int unsigned CALLSTK_DATA_W = 16;
  localparam int unsigned CALLSTK_DEPTH  = 16;

  localparam logic OP_CALL = 1'b1;
  localparam logic OP_RET  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP,
    CAPT,
    RESP
  } state_t;

endpackage

// File: rtl/call_stack_ctrl.sv
// CALL/RET request controller driving a 16-bit return-address LIFO stack.
// Overflow/underflow guarding is enabled by defining CALL_STACK_CTRL_GUARD_EN.
module call_stack_ctrl
  import callstk_pkg::*;
#(
  parameter int unsigned DATA_W = CALLSTK_DATA_W,
  parameter int unsigned DEPTH  = CALLSTK_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_addr,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  depth,
  output logic              stk_enable,
  output logic              stk_operation,
  output logic [DATA_W-1:0] stk_data_in,
  input  logic [DATA_W-1:0] stk_data_out,
  input  logic              stk_full,
  input  logic              stk_empty
);

  localparam logic [CNT_W-1:0] DEPTH_MAX = CNT_W'(DEPTH - 1);

  state_t              state_q;
  state_t              state_d;
  logic                req_ready_d;
  logic                rsp_valid_d;
  logic                rsp_err_d;
  logic [DATA_W-1:0]   rsp_addr_d;
  logic [CNT_W-1:0]    depth_d;
  logic                stk_enable_d;
  logic                stk_operation_d;
  logic [DATA_W-1:0]   stk_data_in_d;

  logic                accept_c;
  logic                block_call_c;
  logic                block_ret_c;

  assign accept_c = req_valid & req_ready;

`ifdef CALL_STACK_CTRL_GUARD_EN
  assign block_call_c = stk_full;
  assign block_ret_c  = stk_empty;
`else
  // The stack itself absorbs overflow/underflow; its status flags go unobserved.
  logic unused_flags_c;
  assign unused_flags_c = stk_full | stk_empty;
  assign block_call_c   = 1'b0;
  assign block_ret_c    = 1'b0;
`endif

  // Next-state and next-output decode; every output is registered from its _d value.
  always_comb begin
    state_d         = state_q;
    req_ready_d     = 1'b0;
    rsp_valid_d     = 1'b0;
    rsp_err_d       = 1'b0;
    rsp_addr_d      = '0;
    depth_d         = depth;
    stk_enable_d    = 1'b0;
    stk_operation_d = 1'b0;
    stk_data_in_d   = '0;

    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept_c) begin
          req_ready_d = 1'b0;
          if (req_op == OP_CALL) begin
            if (block_call_c) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
            end else begin
              state_d         = PUSH;
              stk_enable_d    = 1'b1;
              stk_operation_d = 1'b1;
              stk_data_in_d   = req_addr;
            end
          end else begin
            if (block_ret_c) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
            end else begin
              state_d         = POP;
              stk_enable_d    = 1'b1;
              stk_operation_d = 1'b0;
            end
          end
        end
      end

      PUSH: begin
        if (depth != DEPTH_MAX) begin
          depth_d = depth + CNT_W'(1);
        end
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end

      POP: begin
        if (depth != '0) begin
          depth_d = depth - CNT_W'(1);
        end
        state_d = CAPT;
      end

      // Stack data_out is valid here, one cycle after the pop strobe.
      CAPT: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_addr_d  = stk_data_out;
      end

      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_addr      <= '0;
      depth         <= '0;
      stk_enable    <= 1'b0;
      stk_operation <= 1'b0;
      stk_data_in   <= '0;
    end else begin
      state_q       <= state_d;
      req_ready     <= req_ready_d;
      rsp_valid     <= rsp_valid_d;
      rsp_err       <= rsp_err_d;
      rsp_addr      <= rsp_addr_d;
      depth         <= depth_d;
      stk_enable    <= stk_enable_d;
      stk_operation <= stk_operation_d;
      stk_data_in   <= stk_data_in_d;
    end
  end

  a_depth_bounded : assert property (@(posedge clk) disable iff (!rst_n)
    depth <= DEPTH_MAX);

  a_strobe_only_in_op : assert property (@(posedge clk) disable iff (!rst_n)
    stk_enable |-> (state_q == PUSH || state_q == POP));

  a_ready_only_idle : assert property (@(posedge clk) disable iff (!rst_n)
    req_ready == (state_q == IDLE));

endmodule
